ov5640_cfg_seq: RTL and testbench
=================================

# ov5640_cfg_seq

Parametrised register-configuration sequencer for the OV5640 camera. It sits between a table ROM and the SCCB/IIC master. After power-up it walks a table of {reg_addr, reg_val} entries and issues one IIC write per entry. Beyond the fixed 251-entry initialiser it adds in-table delay entries, NACK detection with an error state, software restart, and an optional retry-on-NACK feature.

## Interface
Parameters:
- ADDR_W, 16: register address field width.
- DATA_W, 8: register value field width.
- REG_NUM, 251: number of table entries, including delay entries.
- IDX_W, 8: width of the table index. Must satisfy 2^IDX_W > REG_NUM.
- CNT_WAIT_MAX, 20000: power-up wait, in sys_clk cycles.
- DLY_UNIT, 1000: sys_clk cycles per delay unit.
- MAX_RETRY, 3: number of re-issues after a NACK. Used only when CFG_RETRY_EN is defined.

Ports:
- sys_clk  in  1: clock.
- sys_rst_n  in  1: reset, asynchronous, active-low.
- cfg_restart  in  1: pulse that restarts the table walk. Honoured only in DONE or ERR.
- cfg_end  in  1: single-cycle pulse from the IIC master when a write finishes.
- cfg_nack  in  1: NACK flag from the IIC master. Valid only in the cycle cfg_end is high.
- rom_addr  out  IDX_W: table index, combinationally equal to idx.
- rom_data  in  ADDR_W+DATA_W: table entry {addr, val}, combinational read.
- cfg_start  out  1: one-cycle write trigger to the IIC master.
- cfg_data  out  ADDR_W+DATA_W: {addr, val} presented to the IIC master.
- cfg_done  out  1: all entries written.
- cfg_err  out  1: table walk aborted on NACK.
- reg_cnt  out  IDX_W: number of entries completed. In ERR, holds the index of the failing entry.

## Operation
State machine: WAIT_PWR, FETCH, ISSUE, BUSY, DELAY, DONE, ERR. Reset state is WAIT_PWR.

- **WAIT_PWR:** the wait counter runs from 0 to CNT_WAIT_MAX-1, then the state moves to FETCH.
- **FETCH** (1 cycle):
  - If idx == REG_NUM, go to DONE.
  - If the rom_data addr field is all ones, the entry is a delay entry. Load units = val.
    - units == 0: idx+1, stay in FETCH.
    - units != 0: go to DELAY.
  - Otherwise, register cfg_data <= rom_data and go to ISSUE.
- **ISSUE** (1 cycle): cfg_start = 1, then go to BUSY.
- **BUSY:** wait for cfg_end.
  - cfg_end with nack = 0: idx+1, clear the retry counter, go to FETCH.
  - cfg_end with nack = 1: go to ERR (behaviour with retry is under Configuration).
- **DELAY:** a sub-counter counts DLY_UNIT cycles, then decrements units. When units reaches 0: idx+1, go to FETCH. A delay entry of N units therefore occupies N*DLY_UNIT cycles in DELAY. No IIC traffic is generated.
- **DONE:** cfg_done = 1 and cfg_data = 0. Holds until cfg_restart or reset.
- **ERR:** cfg_err = 1. idx is frozen at the failing entry. Holds until cfg_restart or reset.
- **cfg_restart** in DONE or ERR:
  - idx = 0; cfg_done, cfg_err and the retry counter are cleared.
  - The next state is FETCH; no power-up wait.
  - In all other states cfg_restart is ignored.
- cfg_end outside BUSY is ignored.
- reg_cnt = idx at all times.

## Timing
- Reset values: cfg_start 0, cfg_data 0, cfg_done 0, cfg_err 0, reg_cnt 0, state WAIT_PWR, all counters 0.
- After reset release (release cycle = cycle 0), FETCH occurs at cycle CNT_WAIT_MAX and the first cfg_start at cycle CNT_WAIT_MAX+1.
- cfg_end in cycle c: FETCH at c+1, next cfg_start at c+2.
- cfg_data is registered. It is stable from the ISSUE cycle until the next write's FETCH.
- cfg_start is never high for two consecutive cycles.
- When the last entry's cfg_end arrives in cycle c: FETCH at c+1, cfg_done high from c+2.
- A NACK in cycle c: cfg_err high from c+1.
- Reset mid-operation aborts immediately. No cfg_start is generated until the power-up wait has completed again.
- All state is on sys_clk; there are no combinational paths from cfg_end to cfg_start.

## Configuration
CFG_RETRY_EN:
- **Defined:** on a NACK with retry < MAX_RETRY, retry+1 and return to FETCH on the same idx. The same entry is re-issued, with cfg_start 2 cycles after cfg_end. The NACK that arrives with retry == MAX_RETRY goes to ERR.
- **Undefined:** the retry counter is not built, and the first NACK goes to ERR.

## Test plan
Bench parameters: REG_NUM=4, CNT_WAIT_MAX=10, DLY_UNIT=5. The IIC model acks 3 cycles after cfg_start.

- **Basic walk.** Table of 4 plain writes, all acked:
  - cfg_start first high at cycle 11, then 4 pulses in total.
  - cfg_data matches each entry in order.
  - cfg_done rises 2 cycles after the 4th cfg_end; cfg_data = 0 afterwards; reg_cnt = 4.
- **Delay entry.** Entry 1 = {16'hFFFF, 8'h03}:
  - 15 cycles in DELAY with cfg_start low.
  - The IIC model sees 3 writes; reg_cnt = 4 at done.
- **Zero delay.** Entry 2 = {16'hFFFF, 8'h00}: it is skipped in a single FETCH cycle, with no stall.
- **NACK, retry disabled.** NACK on entry 2:
  - cfg_err rises 1 cycle later; reg_cnt = 2; no further cfg_start.
  - Pulse cfg_restart: the walk restarts from index 0 without the power-up wait, and cfg_err clears.
- **NACK, CFG_RETRY_EN defined.** Entry 1 NACKed twice then acked: 3 cfg_start pulses with identical cfg_data, then a normal finish with cfg_err = 0. Entry 1 NACKed 4 times: ERR after the 4th NACK.
- **Reset mid-walk.** Assert sys_rst_n low during BUSY of entry 2:
  - All outputs return to 0 immediately.
  - After release, the first cfg_start is at cycle 11 again, for entry 0.

Source files
------------

// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-configuration sequencer: walks a {reg_addr, reg_val} table and issues one IIC write per entry.
// Optional build macro CFG_RETRY_EN re-issues a NACKed entry up to MAX_RETRY times before aborting.
module ov5640_cfg_seq #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int REG_NUM      = 251,
  parameter int IDX_W        = 8,
  parameter int CNT_WAIT_MAX = 20000,
  parameter int DLY_UNIT     = 1000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     cfg_restart,
  input  logic                     cfg_end,
  input  logic                     cfg_nack,
  output logic [IDX_W-1:0]         rom_addr,
  input  logic [ADDR_W+DATA_W-1:0] rom_data,
  output logic                     cfg_start,
  output logic [ADDR_W+DATA_W-1:0] cfg_data,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [IDX_W-1:0]         reg_cnt
);

  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam int WAIT_W = (CNT_WAIT_MAX > 1) ? $clog2(CNT_WAIT_MAX) : 1;
  localparam int DLY_W  = (DLY_UNIT > 1) ? $clog2(DLY_UNIT) : 1;

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_FETCH,
    S_ISSUE,
    S_BUSY,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [DLY_W-1:0]    r_dly_cnt;
  logic [DATA_W-1:0]   r_units;
  logic [IDX_W-1:0]    r_idx;
  logic [ENT_W-1:0]    r_cfg_data;

  logic                w_is_dly;
  logic [DATA_W-1:0]   w_units;
  logic                w_last;
  logic                w_wait_end;
  logic                w_unit_end;
  logic                w_retry_ok;

  // Delay entries are tagged by an all-ones register address; the value field is the unit count.
  assign w_is_dly   = &rom_data[ENT_W-1 -: ADDR_W];
  assign w_units    = rom_data[DATA_W-1:0];
  assign w_last     = (r_idx == IDX_W'(REG_NUM));
  assign w_wait_end = (r_wait_cnt == WAIT_W'(CNT_WAIT_MAX - 1));
  assign w_unit_end = (r_dly_cnt == DLY_W'(DLY_UNIT - 1));

`ifdef CFG_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0] r_retry;

  assign w_retry_ok = (r_retry < RTY_W'(MAX_RETRY));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_retry <= '0;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (cfg_end) begin
            if (!cfg_nack)      r_retry <= '0;
            else if (w_retry_ok) r_retry <= r_retry + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (cfg_restart) r_retry <= '0;
        end
        default: ;
      endcase
    end
  end
`else
  assign w_retry_ok = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_WAIT_PWR;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_PWR: if (w_wait_end) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_last)                         w_state_nxt = S_DONE;
        else if (w_is_dly && w_units != '0) w_state_nxt = S_DELAY;
        else if (!w_is_dly)                 w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (cfg_end) begin
          if (!cfg_nack || w_retry_ok) w_state_nxt = S_FETCH;
          else                         w_state_nxt = S_ERR;
        end
      end
      S_DELAY: if (w_unit_end && r_units == DATA_W'(1)) w_state_nxt = S_FETCH;
      S_DONE, S_ERR: if (cfg_restart) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_WAIT_PWR;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wait_cnt <= '0;
      r_dly_cnt  <= '0;
      r_units    <= '0;
      r_idx      <= '0;
      r_cfg_data <= '0;
    end else begin
      case (r_state)
        S_WAIT_PWR: begin
          if (w_wait_end) r_wait_cnt <= '0;
          else            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        S_FETCH: begin
          if (w_last) begin
            r_cfg_data <= '0;
          end else if (w_is_dly) begin
            // A zero-length delay is consumed here so it costs only this cycle.
            if (w_units == '0) begin
              r_idx <= r_idx + 1'b1;
            end else begin
              r_units   <= w_units;
              r_dly_cnt <= '0;
            end
          end else begin
            r_cfg_data <= rom_data;
          end
        end
        S_BUSY: begin
          if (cfg_end && !cfg_nack) r_idx <= r_idx + 1'b1;
        end
        S_DELAY: begin
          if (w_unit_end) begin
            r_dly_cnt <= '0;
            r_units   <= r_units - 1'b1;
            if (r_units == DATA_W'(1)) r_idx <= r_idx + 1'b1;
          end else begin
            r_dly_cnt <= r_dly_cnt + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (cfg_restart) r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr  = r_idx;
  assign reg_cnt   = r_idx;
  assign cfg_data  = r_cfg_data;
  assign cfg_start = (r_state == S_ISSUE);
  assign cfg_done  = (r_state == S_DONE);
  assign cfg_err   = (r_state == S_ERR);

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Directed bench for ov5640_cfg_seq with a 4-entry table and an IIC model that acks 3 cycles after cfg_start.
`timescale 1ns/1ps
module tb_ov5640_cfg_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        cfg_restart = 1'b0;
  logic        cfg_end = 1'b0;
  logic        cfg_nack = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic        cfg_start;
  logic [23:0] cfg_data;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  reg_cnt;

  logic [23:0] tbl [4];

  int n_chk = 0;
  int n_err = 0;

  // model-owned records
  int cyc = 0;
  int nst = 0;
  int nen = 0;
  int st [64];
  int en [64];
  logic [23:0] lg [64];
  int pend = 0;
  int viol = 0;
  int done_rise = -1;
  int err_rise = -1;
  int nack_tot = 0;
  logic prev_st = 1'b0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  // bench-owned control
  int nack_idx = 0;
  int nack_lim = 0;
  int nack_base = 0;

  ov5640_cfg_seq #(
    .REG_NUM(4),
    .CNT_WAIT_MAX(10),
    .DLY_UNIT(5)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .cfg_restart(cfg_restart),
    .cfg_end(cfg_end),
    .cfg_nack(cfg_nack),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .cfg_start(cfg_start),
    .cfg_data(cfg_data),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err),
    .reg_cnt(reg_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  assign rom_data = (rom_addr < 8'd4) ? tbl[rom_addr[1:0]] : 24'd0;

  // IIC master model: cfg_end in cycle s+3 for a cfg_start in cycle s
  always @(negedge sys_clk) begin
    cfg_end  = 1'b0;
    cfg_nack = 1'b0;
    if (!sys_rst_n) begin
      pend = 0;
    end else begin
      if (cfg_start) begin
        if (prev_st) viol++;
        if (nst < 64) begin
          st[nst] = cyc;
          lg[nst] = cfg_data;
        end
        nst++;
        pend = 3;
      end else if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          cfg_end = 1'b1;
          if ((nack_tot - nack_base) < nack_lim && int'(rom_addr) == nack_idx) begin
            cfg_nack = 1'b1;
            nack_tot++;
          end
          if (nen < 64) en[nen] = cyc;
          nen++;
        end
      end
      if (cfg_done && !prev_done) done_rise = cyc;
      if (cfg_err && !prev_err) err_rise = cyc;
    end
    prev_st   = cfg_start;
    prev_done = cfg_done;
    prev_err  = cfg_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_fin(input string tag, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = cfg_done || cfg_err;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  int rs = 0;
  int rel = 0;
  int b = 0;
  int eb = 0;

  task automatic restart();
    tick();
    cfg_restart = 1'b1;
    rs = cyc;
    tick();
    cfg_restart = 1'b0;
  endtask

  initial begin
    tbl[0] = 24'h300882;
    tbl[1] = 24'h310303;
    tbl[2] = 24'h3017FF;
    tbl[3] = 24'h43006F;

    // reset values
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_start", 32'(cfg_start), 32'd0);
    chk("rst_data",  32'(cfg_data),  32'd0);
    chk("rst_done",  32'(cfg_done),  32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);
    chk("rst_cnt",   32'(reg_cnt),   32'd0);

    // basic walk
    repeat (3) tick();
    rel = cyc;
    b = nst;
    eb = nen;
    sys_rst_n = 1'b1;
    wait_fin("t1_tmo", 200);
    chk("t1_first_start", 32'(st[b] - rel), 32'd11);
    chk("t1_nstart", 32'(nst - b), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_data", 32'(lg[b+i]), 32'(tbl[i]));
    chk("t1_done_lat", 32'(done_rise - en[eb+3]), 32'd2);
    chk("t1_data_zero", 32'(cfg_data), 32'd0);
    chk("t1_reg_cnt", 32'(reg_cnt), 32'd4);
    chk("t1_done", 32'(cfg_done), 32'd1);

    // delay entry of 3 units
    tbl[1] = 24'hFFFF03;
    restart();
    chk("t2_done_clr", 32'(cfg_done), 32'd0);
    b = nst;
    eb = nen;
    wait_fin("t2_tmo", 300);
    chk("t2_nstart", 32'(nst - b), 32'd3);
    chk("t2_restart_lat", 32'(st[b] - rs), 32'd2);
    chk("t2_dly_gap", 32'(st[b+1] - en[eb]), 32'd18);
    chk("t2_data", 32'(lg[b+1]), 32'(tbl[2]));
    chk("t2_reg_cnt", 32'(reg_cnt), 32'd4);

    // zero-length delay
    tbl[1] = 24'h310303;
    tbl[2] = 24'hFFFF00;
    restart();
    b = nst;
    eb = nen;
    wait_fin("t3_tmo", 300);
    chk("t3_nstart", 32'(nst - b), 32'd3);
    chk("t3_skip_gap", 32'(st[b+2] - en[eb+1]), 32'd3);
    chk("t3_data", 32'(lg[b+2]), 32'(tbl[3]));
    chk("t3_reg_cnt", 32'(reg_cnt), 32'd4);
    tbl[2] = 24'h3017FF;

`ifndef CFG_RETRY_EN
    // NACK on entry 2 aborts the walk
    nack_idx = 2;
    nack_base = nack_tot;
    nack_lim = 1;
    restart();
    b = nst;
    eb = nen;
    wait_fin("t4_tmo", 300);
    chk("t4_err", 32'(cfg_err), 32'd1);
    chk("t4_done", 32'(cfg_done), 32'd0);
    chk("t4_reg_cnt", 32'(reg_cnt), 32'd2);
    chk("t4_err_lat", 32'(err_rise - en[eb+2]), 32'd1);
    repeat (20) tick();
    chk("t4_no_more_start", 32'(nst - b), 32'd3);
    chk("t4_err_hold", 32'(cfg_err), 32'd1);
    restart();
    chk("t4_err_clr", 32'(cfg_err), 32'd0);
    b = nst;
    wait_fin("t4r_tmo", 300);
    chk("t4r_restart_lat", 32'(st[b] - rs), 32'd2);
    chk("t4r_first_data", 32'(lg[b]), 32'(tbl[0]));
    chk("t4r_nstart", 32'(nst - b), 32'd4);
    chk("t4r_done", 32'(cfg_done), 32'd1);
`else
    // entry 1 NACKed twice, then acked
    nack_idx = 1;
    nack_base = nack_tot;
    nack_lim = 2;
    restart();
    b = nst;
    eb = nen;
    wait_fin("t4_tmo", 300);
    chk("t4_nstart", 32'(nst - b), 32'd6);
    for (int i = 1; i < 4; i++) chk("t4_retry_data", 32'(lg[b+i]), 32'(tbl[1]));
    chk("t4_retry_lat", 32'(st[b+2] - en[eb+1]), 32'd2);
    chk("t4_err", 32'(cfg_err), 32'd0);
    chk("t4_done", 32'(cfg_done), 32'd1);
    // entry 1 NACKed four times
    nack_base = nack_tot;
    nack_lim = 4;
    restart();
    b = nst;
    eb = nen;
    wait_fin("t4e_tmo", 400);
    chk("t4e_err", 32'(cfg_err), 32'd1);
    chk("t4e_nstart", 32'(nst - b), 32'd5);
    chk("t4e_reg_cnt", 32'(reg_cnt), 32'd1);
    chk("t4e_err_lat", 32'(err_rise - en[eb+4]), 32'd1);
`endif

    // reset during BUSY of entry 2
    nack_lim = 0;
    restart();
    b = nst;
    for (int i = 0; i < 200 && (nst - b) < 3; i++) tick();
    chk("t5_reach_busy", 32'(nst - b), 32'd3);
    tick();
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_start", 32'(cfg_start), 32'd0);
    chk("t5_rst_data",  32'(cfg_data),  32'd0);
    chk("t5_rst_done",  32'(cfg_done),  32'd0);
    chk("t5_rst_err",   32'(cfg_err),   32'd0);
    chk("t5_rst_cnt",   32'(reg_cnt),   32'd0);
    repeat (2) tick();
    rel = cyc;
    b = nst;
    sys_rst_n = 1'b1;
    wait_fin("t5_tmo", 200);
    chk("t5_first_start", 32'(st[b] - rel), 32'd11);
    chk("t5_first_data", 32'(lg[b]), 32'(tbl[0]));
    chk("t5_nstart", 32'(nst - b), 32'd4);
    chk("no_back_to_back_start", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
